// File: rtl/lbist_seq_ctrl.sv
// ---------------------------------------------------------------------------
// lbist_seq_ctrl
//
// Sequences logic-BIST runs across up to NUM_CH channels, one channel at a
// time in ascending index order. For each enabled channel the controller
// raises that channel's test-mode request, waits for the engine to
// acknowledge (go_nogo high), then waits for a low phase followed by a high
// phase. It then evaluates the final go/no-go level. Failed or timed-out
// attempts are retried up to MAX_RETRY times, with a two-cycle gap during
// which the test-mode request is dropped. A done pulse closes the sequence.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   start_i        sequence start request (honoured only while idle)
//   abort_i        synchronous abort; ends the sequence through DONE
//   ch_en_i        channel enable mask, latched when a sequence starts
//   go_nogo_i      per-channel BIST engine status
//   test_normal_o  per-channel test-mode request (1 = test), at most one high
//   busy_o         high while the sequencer is not idle
//   done_o         one-cycle pulse at the end of a sequence
//   pass_o         all enabled channels passed; valid from done_o to next start
//   ch_pass_o      per-channel final pass flag
//   ch_tmo_o       per-channel flag: the last attempt ended in a timeout
// ---------------------------------------------------------------------------
module lbist_seq_ctrl #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned START_TO  = 64,
  parameter int unsigned RUN_TO    = 40000,
  parameter int unsigned MAX_RETRY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  input  logic [NUM_CH-1:0] go_nogo_i,
  output logic [NUM_CH-1:0] test_normal_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [NUM_CH-1:0] ch_pass_o,
  output logic [NUM_CH-1:0] ch_tmo_o
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned RTY_W = 3;

  // Timeouts fire on the last counted cycle, so a phase lasts exactly
  // START_TO (or RUN_TO) cycles before it is declared timed out.
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TO - 1);
  localparam logic [CNT_W-1:0] RUN_LIM   = CNT_W'(RUN_TO - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WAIT_START,
    RUN_LOW,
    RUN_HIGH,
    EVAL,
    GAP,
    DONE
  } state_e;

  state_e            state_q;
  logic [NUM_CH-1:0] chEn_q;
  logic [NUM_CH-1:0] chDone_q;
  logic [NUM_CH-1:0] chPass_q;
  logic [NUM_CH-1:0] chTmo_q;
  logic [NUM_CH-1:0] testNormal_q;
  logic [CH_W-1:0]   curCh_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [RTY_W-1:0]  retry_q;
  logic              gap_q;
  logic              done_q;
  logic              pass_q;

  logic [CNT_W-1:0]  cnt_d;
  logic [NUM_CH-1:0] remain_d;
  logic              selFound_d;
  logic [CH_W-1:0]   selCh_d;
  logic              goCur_d;
  logic              failNow_d;
  logic              tmoNow_d;
  logic              passAll_d;

  // The counter sticks at all-ones instead of wrapping, so a limit larger
  // than the counter range can never be skipped past.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Lowest-index enabled channel that has not completed yet.
  always_comb begin
    remain_d   = chEn_q & ~chDone_q;
    selFound_d = 1'b0;
    selCh_d    = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (remain_d[i] && !selFound_d) begin
        selFound_d = 1'b1;
        selCh_d    = CH_W'(i);
      end
    end
  end

  // Status of the channel under test, and the aggregate pass result in which
  // disabled channels count as passing.
  always_comb begin
    goCur_d   = go_nogo_i[curCh_q];
    passAll_d = &(chPass_q | ~chEn_q);
  end

  // An attempt ends badly when the waited-for level never shows up within
  // the phase budget (timeout) or when the evaluation cycle sees no-go.
  // The run budget spans RUN_LOW and RUN_HIGH together.
  always_comb begin
    failNow_d = 1'b0;
    tmoNow_d  = 1'b0;
    case (state_q)
      WAIT_START: begin
        if (!goCur_d && (cnt_q >= START_LIM)) begin
          failNow_d = 1'b1;
          tmoNow_d  = 1'b1;
        end
      end
      RUN_LOW: begin
        if (goCur_d && (cnt_q >= RUN_LIM)) begin
          failNow_d = 1'b1;
          tmoNow_d  = 1'b1;
        end
      end
      RUN_HIGH: begin
        if (!goCur_d && (cnt_q >= RUN_LIM)) begin
          failNow_d = 1'b1;
          tmoNow_d  = 1'b1;
        end
      end
      EVAL: begin
        if (!goCur_d) begin
          failNow_d = 1'b1;
        end
      end
      default: begin
        failNow_d = 1'b0;
        tmoNow_d  = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered outputs. Abort takes precedence over all
  // other activity; a bad attempt either schedules a retry through GAP or
  // closes the channel with its timeout flag reflecting the last attempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      chEn_q       <= '0;
      chDone_q     <= '0;
      chPass_q     <= '0;
      chTmo_q      <= '0;
      testNormal_q <= '0;
      curCh_q      <= '0;
      cnt_q        <= '0;
      retry_q      <= '0;
      gap_q        <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i && (state_q != IDLE) && (state_q != DONE)) begin
        testNormal_q <= '0;
        retry_q      <= '0;
        done_q       <= 1'b1;
        pass_q       <= passAll_d;
        state_q      <= DONE;
      end else if (failNow_d) begin
        testNormal_q <= '0;
        if (retry_q < RTY_MAX) begin
          retry_q <= retry_q + RTY_W'(1);
          gap_q   <= 1'b0;
          state_q <= GAP;
        end else begin
          chDone_q[curCh_q] <= 1'b1;
          chTmo_q[curCh_q]  <= tmoNow_d;
          retry_q           <= '0;
          state_q           <= SELECT;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              chEn_q   <= ch_en_i;
              chDone_q <= '0;
              chPass_q <= '0;
              chTmo_q  <= '0;
              pass_q   <= 1'b0;
              retry_q  <= '0;
              state_q  <= SELECT;
            end
          end
          SELECT: begin
            if (selFound_d) begin
              curCh_q      <= selCh_d;
              testNormal_q <= NUM_CH'(1) << selCh_d;
              cnt_q        <= '0;
              state_q      <= WAIT_START;
            end else begin
              done_q  <= 1'b1;
              pass_q  <= passAll_d;
              state_q <= DONE;
            end
          end
          WAIT_START: begin
            if (goCur_d) begin
              cnt_q   <= '0;
              state_q <= RUN_LOW;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          RUN_LOW: begin
            cnt_q <= cnt_d;
            if (!goCur_d) begin
              state_q <= RUN_HIGH;
            end
          end
          RUN_HIGH: begin
            cnt_q <= cnt_d;
            if (goCur_d) begin
              state_q <= EVAL;
            end
          end
          EVAL: begin
            chPass_q[curCh_q] <= 1'b1;
            chDone_q[curCh_q] <= 1'b1;
            testNormal_q      <= '0;
            retry_q           <= '0;
            state_q           <= SELECT;
          end
          GAP: begin
            if (gap_q) begin
              testNormal_q <= NUM_CH'(1) << curCh_q;
              cnt_q        <= '0;
              state_q      <= WAIT_START;
            end else begin
              gap_q <= 1'b1;
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign test_normal_o = testNormal_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign ch_pass_o     = chPass_q;
  assign ch_tmo_o      = chTmo_q;

endmodule
